// File: rtl/s_mem_init_multi.sv
// s_mem_init_multi: lockstep fill/verify engine for NUM_CH identical S-array memories
module s_mem_init_multi #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int NUM_CH = 1,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  output logic                     rdy,
  input  logic [1:0]               mode,
  input  logic [DATA_W-1:0]        fill_val,
  output logic [ADDR_W-1:0]        addr,
  output logic [DATA_W-1:0]        wrdata,
  output logic [NUM_CH-1:0]        wren,
  input  logic [NUM_CH*DATA_W-1:0] rddata,
  output logic                     done,
  output logic                     err,
  output logic [NUM_CH-1:0]        err_ch,
  output logic [ADDR_W-1:0]        err_addr
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW = ADDR_W + 1;
  typedef enum logic [1:0] {IDLE, FILL, VERIFY, FINISH} state_t;
  state_t state, state_nx;
  logic [ADDR_W:0] cnt, cnt_nx;
  logic [1:0] mode_q;
  logic [DATA_W-1:0] fill_q;
  logic accept, issue;
  logic [ADDR_W-1:0] pa [RD_LAT];
  logic [RD_LAT-1:0] pv;
  logic [NUM_CH-1:0] mm;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    accept = 1'b0;
    case (state)
      IDLE: if (en) begin
        accept = 1'b1;
        cnt_nx = '0;
        state_nx = mode == 2'd3 ? VERIFY : FILL;
      end
      FILL: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == CW'(DEPTH - 1)) begin
          cnt_nx = '0;
          state_nx = mode_q == 2'd2 ? VERIFY : FINISH;
        end
      end
      VERIFY: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == CW'(DEPTH + RD_LAT - 1)) begin
          cnt_nx = '0;
          state_nx = FINISH;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  // top counter bit set means the verify pass is only draining the read pipeline
  assign issue = state == VERIFY && !cnt[ADDR_W];
  assign rdy = state == IDLE;
  assign done = state == FINISH;
  assign addr = (state == FILL || issue) ? cnt[ADDR_W-1:0] : '0;
  assign wren = {NUM_CH{state == FILL}};
  assign wrdata = state != FILL ? '0 : mode_q == 2'd1 ? fill_q : DATA_W'(cnt[ADDR_W-1:0]);
  always_comb begin
    mm = '0;
    for (int c = 0; c < NUM_CH; c++)
      mm[c] = pv[RD_LAT-1] && rddata[c*DATA_W +: DATA_W] != DATA_W'(pa[RD_LAT-1]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      mode_q <= '0;
      fill_q <= '0;
      pv <= '0;
      for (int i = 0; i < RD_LAT; i++) pa[i] <= '0;
      err <= 1'b0;
      err_ch <= '0;
      err_addr <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      pv[0] <= issue;
      pa[0] <= addr;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
      if (accept) begin
        mode_q <= mode;
        fill_q <= fill_val;
        err <= 1'b0;
        err_ch <= '0;
        err_addr <= '0;
      end else if (|mm) begin
        err <= 1'b1;
        err_ch <= err_ch | mm;
        if (!err) err_addr <= pa[RD_LAT-1];
      end
    end
  end
endmodule

// File: tb/tb_s_mem_init_multi.sv
// tb_s_mem_init_multi: scoreboard bench with a word-level memory model and per-pass expectations
module tb_s_mem_init_multi;
  localparam int AW = 9, DW = 8, NC = 4, RL = 2;
  localparam int D = 1 << AW;
  logic clk = 0, rst_n = 0, en = 0;
  logic [1:0] mode = 0;
  logic [DW-1:0] fill_val = 0;
  logic rdy, done, err;
  logic [AW-1:0] addr, err_addr;
  logic [DW-1:0] wrdata;
  logic [NC-1:0] wren, err_ch;
  logic [NC*DW-1:0] rd0, rd1, rdd;
  logic [DW-1:0] mem [NC][D];
  logic [DW-1:0] refmem [NC][D];
  logic [DW-1:0] cor [NC][D];
  int vec = 0, mis = 0;
  typedef struct {
    int low;
    logic e;
    logic [NC-1:0] ch;
    logic [AW-1:0] ea;
    int wc;
    bit b2b;
  } exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  s_mem_init_multi #(.ADDR_W(AW), .DATA_W(DW), .NUM_CH(NC), .RD_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .mode(mode), .fill_val(fill_val),
    .addr(addr), .wrdata(wrdata), .wren(wren), .rddata(rdd), .done(done),
    .err(err), .err_ch(err_ch), .err_addr(err_addr));
  always @(posedge clk) begin
    for (int c = 0; c < NC; c++) begin
      if (wren[c]) mem[c][addr] <= wrdata;
      rd0[c*DW +: DW] <= mem[c][addr] ^ cor[c][addr];
    end
    rd1 <= rd0;
  end
  assign rdd = RL == 1 ? rd0 : rd1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    vec++;
    if (a !== x) begin
      mis++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask
  task automatic timeout(input string n);
    vec++;
    mis++;
    $display("FAIL %s: timed out", n);
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  endtask
  function automatic exp_t model(input logic [1:0] m, input logic [DW-1:0] fv, input bit b2b);
    exp_t r;
    logic [NC-1:0] bad;
    r.low = m == 2 ? 2*D + RL + 1 : m == 3 ? D + RL + 1 : D + 1;
    r.e = 0; r.ch = 0; r.ea = 0; r.b2b = b2b;
    r.wc = m == 3 ? 0 : D;
    if (m != 3)
      for (int a = 0; a < D; a++)
        for (int c = 0; c < NC; c++) refmem[c][a] = m == 1 ? fv : DW'(a);
    if (m >= 2)
      for (int a = 0; a < D; a++) begin
        bad = 0;
        for (int c = 0; c < NC; c++) bad[c] = (refmem[c][a] ^ cor[c][a]) != DW'(a);
        if (bad != 0 && !r.e) begin r.e = 1; r.ea = AW'(a); end
        r.ch |= bad;
      end
    return r;
  endfunction
  // monitor: pops one expectation per done pulse and checks the finished pass
  int low = 0, wcnt = 0, post = 0;
  bit wbad = 0;
  exp_t pe;
  always @(negedge clk) begin
    if (!rst_n) begin
      low = 0; wcnt = 0; wbad = 0; post = 0;
    end else begin
      if (post == 1) begin
        chk("post_idle", {rdy, done, err, err_ch, err_addr}, {1'b1, 1'b0, pe.e, pe.ch, pe.ea});
        post = pe.b2b ? 2 : 0;
      end else if (post == 2) begin
        chk("b2b_restart", rdy, 0);
        post = 0;
      end
      if (!rdy) low++;
      else begin low = 0; wcnt = 0; wbad = 0; end
      if (wren != 0) wcnt++;
      if (wren != 0 && wren != {NC{1'b1}}) wbad = 1;
      if (done) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          int nb = 0;
          pe = q.pop_front();
          chk("rdy_low", low, pe.low);
          chk("err_state", {err, err_ch, err_addr}, {pe.e, pe.ch, pe.ea});
          chk("wren_cycles", wcnt, pe.wc);
          chk("wren_equal", wbad, 0);
          for (int c = 0; c < NC; c++)
            for (int a = 0; a < D; a++) if (mem[c][a] !== refmem[c][a]) nb++;
          chk("mem_words_bad", nb, 0);
          post = 1;
        end
      end
    end
  end
  task automatic wait_rdy();
    int n = 0;
    do begin @(negedge clk); n++; end while (!rdy && n < 4*D);
    if (!rdy) timeout("wait_rdy");
  endtask
  task automatic wait_done();
    int n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 4*D);
    if (!done) timeout("wait_done");
  endtask
  task automatic start(input logic [1:0] m, input logic [DW-1:0] fv, input bit noise);
    wait_rdy();
    q.push_back(model(m, fv, 0));
    mode = m; fill_val = fv; en = 1;
    @(posedge clk); #1 en = 0;
    if (noise) begin
      repeat (2) @(negedge clk);
      en = 1; mode = 2'($urandom); fill_val = DW'($urandom);
      repeat (3) @(negedge clk);
      en = 0;
    end
    wait_done();
  endtask
  task automatic clear_cor();
    for (int c = 0; c < NC; c++)
      for (int a = 0; a < D; a++) cor[c][a] = 0;
  endtask
  initial begin
    for (int c = 0; c < NC; c++)
      for (int a = 0; a < D; a++) begin
        refmem[c][a] = DW'($urandom);
        mem[c][a] <= refmem[c][a];
      end
    clear_cor();
    #23;
    chk("rst_rdy", rdy, 1);
    chk("rst_wren", wren, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wrdata", wrdata, 0);
    chk("rst_done", done, 0);
    chk("rst_err", {err, err_ch, err_addr}, 0);
    @(negedge clk); #2 rst_n = 1;
    start(3, 0, 0);
    start(0, 0, 0);
    start(3, 0, 1);
    start(1, 8'hA5, 1);
    cor[2][9'h037] = 8'h10;
    cor[0][9'h0C0] = 8'h01;
    start(2, 0, 0);
    chk("dir_err", err, 1);
    chk("dir_err_ch", err_ch, 4'b0101);
    chk("dir_err_addr", err_addr, 9'h037);
    clear_cor();
    // reset in the middle of a fill pass
    wait_rdy();
    q.push_back(model(0, 0, 0));
    mode = 0; en = 1;
    @(posedge clk); #1 en = 0;
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!(addr == 100 && wren != 0) && n < 2*D);
      if (addr != 100) timeout("wait_addr100");
    end
    #2 rst_n = 0;
    #1;
    chk("midrst_wren", wren, 0);
    chk("midrst_rdy", rdy, 1);
    chk("midrst_outs", {addr, wrdata, done, err, err_ch, err_addr}, 0);
    q.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    start(0, 0, 0);
    // en held high across three passes
    wait_rdy();
    mode = 0; en = 1;
    for (int k = 0; k < 3; k++) begin
      q.push_back(model(0, 0, k < 2));
      wait_done();
    end
    @(posedge clk); #1 en = 0;
    for (int i = 0; i < 16; i++) begin
      logic [1:0] m;
      clear_cor();
      if ($urandom_range(0, 1)) begin
        int k = $urandom_range(1, 3);
        for (int j = 0; j < k; j++)
          cor[$urandom_range(0, NC-1)][$urandom_range(0, D-1)] = DW'($urandom_range(1, 255));
      end
      m = 2'($urandom_range(0, 3));
      start(m, DW'($urandom), 1'($urandom_range(0, 1)));
    end
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
  initial begin
    #2000000;
    timeout("global_watchdog");
  end
endmodule

// File: doc/s_mem_init_multi.md
Name: s_mem_init_multi

Overview:
- Parametrised successor to the single-memory S-array initialiser.
- Drives NUM_CH identical-depth single-port memories in lockstep, one per parallel cracking core.
- Four modes: identity fill (S[i]=i), constant fill, identity fill followed by pipelined read-back verify, and verify-only.
- Uses the codebase rdy/en handshake and sits between the top-level controller and the per-core S memories.

Parameters:
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words per memory.
- DATA_W, 8, memory word width.
- NUM_CH, 1, number of memories driven in lockstep (>=1).
- RD_LAT, 1, memory read latency in cycles (1 or 2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  start request; accepted only when rdy=1.
- rdy  out  1  high when idle and able to accept en.
- mode  in  2  0=identity fill, 1=constant fill, 2=identity fill+verify, 3=verify-only; latched on accept.
- fill_val  in  DATA_W  constant for mode 1; latched on accept.
- addr  out  ADDR_W  shared address to all memories.
- wrdata  out  DATA_W  shared write data.
- wren  out  NUM_CH  per-memory write enable; all bits always equal.
- rddata  in  NUM_CH*DATA_W  read data; channel c occupies bits [c*DATA_W +: DATA_W].
- done  out  1  one-cycle pulse at operation end.
- err  out  1  verify mismatch seen; sticky until next accepted en.
- err_ch  out  NUM_CH  OR of per-channel mismatch bits across the whole verify pass.
- err_addr  out  ADDR_W  address of the first mismatch.

Behaviour:
- Reset values: rdy=1, wren=0, addr=0, wrdata=0, done=0, err=0, err_ch=0, err_addr=0; FSM in IDLE.
- Reset asserted mid-operation forces wren=0 immediately (asynchronous), abandons the pass, and returns to IDLE.
- IDLE: rdy=1. When en=1, latch mode and fill_val, clear err/err_ch/err_addr, then go to FILL (modes 0,1,2) or VERIFY (mode 3). rdy=0 from the next cycle.
- en while rdy=0 is ignored.
- FILL:
  - Writes one word per cycle, addr=0..DEPTH-1, wren all-ones.
  - wrdata = addr truncated/zero-extended to DATA_W (modes 0,2) or fill_val (mode 1). Identity values wrap mod 2**DATA_W when ADDR_W>DATA_W.
  - Exactly DEPTH write cycles. After addr=DEPTH-1: modes 0,1 go to FINISH; mode 2 goes to VERIFY with addr reset to 0.
- VERIFY:
  - wren=0. Issues addr=0..DEPTH-1 one per cycle.
  - The expected value (identity) is delayed RD_LAT cycles alongside a valid bit and compared against each channel's rddata.
  - Any mismatch sets err and ORs the channel bits into err_ch. err_addr captures the delayed address on the first mismatch only.
  - After the last address issues, drain RD_LAT cycles, then go to FINISH.
  - VERIFY length: DEPTH+RD_LAT cycles.
- FINISH: one cycle, done=1, addr=0, wren=0. Next cycle IDLE with rdy=1.
- Total rdy-low cycles, counted from the cycle after the en accept edge:
  - modes 0,1: DEPTH+1.
  - mode 2: 2*DEPTH+RD_LAT+1.
  - mode 3: DEPTH+RD_LAT+1.
- en held high continuously starts a new pass on the first IDLE cycle. Back-to-back passes leave exactly one rdy=1 cycle between them.
- err/err_ch/err_addr hold after done until the next accept. They are never set in modes 0 and 1.
- Address counter is ADDR_W+1 bits internally; no wrap glitch at DEPTH-1.

Test Plan:
- Defaults, mode 0, en pulse after reset → memory[i]=i for i=0..255; rdy low exactly 257 cycles; done single pulse; err=0.
- NUM_CH=4, mode 1, fill_val=8'hA5 → all 4×256 words = 8'hA5; wren bits identical every cycle.
- NUM_CH=4, mode 2, bench memory model corrupts ch2 addr 8'h37 and ch0 addr 8'hC0 → err=1, err_ch=4'b0101, err_addr=8'h37; rdy low 514 cycles.
- Mode 0, rst_n pulled low while addr=100 → wren=0 in the same cycle, rdy=1, all outputs at reset values. A following mode 0 pass completes correctly from addr 0.
- ADDR_W=9, DATA_W=8, mode 3 on memory prefilled with i mod 256 → err=0, done after 512+RD_LAT+1 cycles. RD_LAT=2 variant gives the same result.
- en held high across three passes in mode 0 → exactly one rdy=1 cycle between passes. en pulses during busy have no effect.
